// File: rtl/jtpang_objdma_pkg.sv
// Shared constants for the object DMA engine and the object renderer.
package jtpang_objdma_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_RD   = 3'd2;
  localparam logic [2:0] ST_WR   = 3'd3;
  localparam logic [2:0] ST_REL  = 3'd4;

  localparam int          OBJ_LEN     = 512;
  localparam logic [11:0] OBJ_SRC_OFS = 12'h000;

  // Byte-index counter width; a one-byte table still needs a 1-bit counter.
  function automatic int idx_width(input int len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

endpackage

// File: rtl/jtpang_objdma_edge.sv
// dma_go rising-edge detector with a sticky pending flag; edges that arrive
// while a request is already pending coalesce into one.
module jtpang_objdma_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_go,
  input  logic i_clr,
  output logic o_pending
);

  logic r_go_l;
  logic r_pending;

  // A new edge wins over a same-cycle clear so the request is not lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_go_l    <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_go_l <= i_go;
      if (i_go && !r_go_l)
        r_pending <= 1'b1;
      else if (i_clr)
        r_pending <= 1'b0;
    end
  end

  assign o_pending = r_pending;

endmodule

// File: rtl/jtpang_objdma.sv
// Object DMA: on a dma_go edge, takes the Z80 bus and copies LEN bytes of VRAM
// into the object buffer. Define JTPANG_OBJDMA_VBLANK_EN to hold the bus request until vertical blank.
module jtpang_objdma
  import jtpang_objdma_pkg::*;
#(
  parameter int          AW      = 9,
  parameter int          LEN     = OBJ_LEN,
  parameter logic [11:0] SRC_OFS = OBJ_SRC_OFS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          dma_go,
  input  logic          LVBL,
  output logic          busrq_n,
  input  logic          busak_n,
  output logic          dma_cs,
  output logic [11:0]   dma_addr,
  input  logic [7:0]    vram_dout,
  output logic [AW-1:0] obj_addr,
  output logic [7:0]    obj_din,
  output logic          obj_we,
  output logic          busy
);

  localparam int            IW   = idx_width(LEN);
  localparam logic [IW-1:0] LAST = IW'(LEN - 1);

  logic [2:0]    r_state;
  logic [2:0]    w_state_next;
  logic [IW-1:0] r_idx;
  logic [AW-1:0] r_obj_addr;
  logic [7:0]    r_obj_din;
  logic          r_obj_we;
  logic          w_pending;
  logic          w_clr;
  logic          w_req_ok;
  logic          w_grant;

  jtpang_objdma_edge u_edge (
    .clk       (clk),
    .rst       (rst),
    .i_go      (dma_go),
    .i_clr     (w_clr),
    .o_pending (w_pending)
  );

`ifdef JTPANG_OBJDMA_VBLANK_EN
  assign w_req_ok = ~LVBL;
`else
  logic w_unused_lvbl;
  assign w_unused_lvbl = LVBL;
  assign w_req_ok      = 1'b1;
`endif

  assign w_grant = ~busak_n;
  assign w_clr   = cen && (r_state == ST_IDLE) && w_pending;

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= ST_IDLE;
    else if (cen)
      r_state <= w_state_next;
  end

  // Losing the grant in RD/WR simply stalls: state and index hold until it returns.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_pending)            w_state_next = ST_REQ;
      ST_REQ:  if (w_req_ok && w_grant)  w_state_next = ST_RD;
      ST_RD:   if (w_grant)              w_state_next = ST_WR;
      ST_WR:   if (w_grant)              w_state_next = (r_idx == LAST) ? ST_REL : ST_RD;
      ST_REL:  if (busak_n)              w_state_next = ST_IDLE;
      default:                           w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busrq_n = 1'b1;
    dma_cs  = 1'b0;
    busy    = 1'b1;
    case (r_state)
      ST_IDLE: busy = 1'b0;
      ST_REQ:  busrq_n = ~w_req_ok;
      ST_RD, ST_WR: begin
        busrq_n = 1'b0;
        dma_cs  = w_grant;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx      <= '0;
      r_obj_addr <= '0;
      r_obj_din  <= 8'd0;
      r_obj_we   <= 1'b0;
    end else begin
      r_obj_we <= 1'b0;
      if (cen) begin
        if (r_state == ST_REQ && w_req_ok && w_grant)
          r_idx <= '0;
        if (r_state == ST_WR && w_grant) begin
          r_obj_addr <= AW'(r_idx);
          r_obj_din  <= vram_dout;
          r_obj_we   <= 1'b1;
          if (r_idx != LAST)
            r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

  // 12-bit sum wraps past the top of VRAM back to 0.
  assign dma_addr = SRC_OFS + 12'(r_idx);
  assign obj_addr = r_obj_addr;
  assign obj_din  = r_obj_din;
  assign obj_we   = r_obj_we;

endmodule

// File: tb/tb_jtpang_objdma.sv
// Bench for jtpang_objdma: two instances (default table and a wrapping 256-byte table),
// a bus arbiter model, and a queue log of object-buffer writes checked against VRAM contents.
`timescale 1ns/1ps
module tb_jtpang_objdma;

  localparam int          LEN_A = 512;
  localparam int          LEN_B = 256;
  localparam logic [11:0] OFS_A = 12'h000;
  localparam logic [11:0] OFS_B = 12'hF80;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic        cen  = 1'b0;
  logic        LVBL = 1'b0;
  logic        go_a = 1'b0, go_b = 1'b0;
  logic        busrq_n_a, busrq_n_b;
  logic        busak_n_a = 1'b1, busak_n_b = 1'b1;
  logic        dma_cs_a, dma_cs_b;
  logic [11:0] dma_addr_a, dma_addr_b;
  logic [7:0]  vram_dout_a = 8'd0, vram_dout_b = 8'd0;
  logic [8:0]  obj_addr_a;
  logic [7:0]  obj_addr_b;
  logic [7:0]  obj_din_a, obj_din_b;
  logic        obj_we_a, obj_we_b;
  logic        busy_a, busy_b;

  logic [7:0]  vram [4096];
  wr_t         log_a[$];
  wr_t         log_b[$];
  logic        busak_edge_a = 1'b1, busak_edge_b = 1'b1;
  int          lost_writes = 0;
  int          grant_dly = 3;
  int          lost_a = 0;
  int          gcnt_a = 0, gcnt_b = 0, ccnt = 0;
  int          n_checks = 0, n_fail = 0;

  jtpang_objdma u_dut_a (
    .clk(clk), .rst(rst), .cen(cen), .dma_go(go_a), .LVBL(LVBL),
    .busrq_n(busrq_n_a), .busak_n(busak_n_a), .dma_cs(dma_cs_a), .dma_addr(dma_addr_a),
    .vram_dout(vram_dout_a), .obj_addr(obj_addr_a), .obj_din(obj_din_a), .obj_we(obj_we_a),
    .busy(busy_a)
  );

  jtpang_objdma #(.AW(8), .LEN(LEN_B), .SRC_OFS(OFS_B)) u_dut_b (
    .clk(clk), .rst(rst), .cen(cen), .dma_go(go_b), .LVBL(LVBL),
    .busrq_n(busrq_n_b), .busak_n(busak_n_b), .dma_cs(dma_cs_b), .dma_addr(dma_addr_b),
    .vram_dout(vram_dout_b), .obj_addr(obj_addr_b), .obj_din(obj_din_b), .obj_we(obj_we_b),
    .busy(busy_b)
  );

  always #5 clk = ~clk;

  // Synchronous VRAM: data for the address seen at an edge appears after it.
  always @(posedge clk) begin
    vram_dout_a  <= vram[dma_addr_a];
    vram_dout_b  <= vram[dma_addr_b];
    busak_edge_a <= busak_n_a;
    busak_edge_b <= busak_n_b;
  end

  // cen every 4th clk; Z80 grants grant_dly cen after the request, releases on the next cen.
  always @(negedge clk) begin
    if (cen) begin
      if (busrq_n_a) begin busak_n_a = 1'b1; gcnt_a = 0; end
      else if (lost_a > 0) begin busak_n_a = 1'b1; lost_a--; end
      else if (gcnt_a >= grant_dly) busak_n_a = 1'b0;
      else gcnt_a++;
      if (busrq_n_b) begin busak_n_b = 1'b1; gcnt_b = 0; end
      else if (gcnt_b >= grant_dly) busak_n_b = 1'b0;
      else gcnt_b++;
    end
    ccnt = (ccnt + 1) % 4;
    cen  = (ccnt == 0);
  end

  // Write logger: every obj_we pulse becomes one entry in the model's write log.
  always @(negedge clk) begin
    wr_t w;
    if (obj_we_a === 1'b1) begin
      w.addr = int'(obj_addr_a);
      w.data = int'(obj_din_a);
      log_a.push_back(w);
      if (busak_edge_a) lost_writes++;
    end
    if (obj_we_b === 1'b1) begin
      w.addr = int'(obj_addr_b);
      w.data = int'(obj_din_b);
      log_b.push_back(w);
      if (busak_edge_b) lost_writes++;
    end
  end

  // Reference: the j-th write of a transfer goes to buffer[j] with VRAM[(ofs+j) mod 4096].
  function automatic int first_bad(input bit dut_b, input int base, input int len, input logic [11:0] ofs);
    wr_t w;
    for (int j = 0; j < len; j++) begin
      if (dut_b) w = log_b[base + j];
      else       w = log_a[base + j];
      if (w.addr != j || w.data != int'(vram[(int'(ofs) + j) % 4096])) return j;
    end
    return -1;
  endfunction

  task automatic wait_writes(input bit dut_b, input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < budget && !ok; t++) begin
      if ((dut_b ? log_b.size() : log_a.size()) >= n) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_idle(input bit dut_b, input int budget, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < budget && !ok; t++) begin
      if ((dut_b ? busy_b : busy_a) === 1'b0) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
  endtask

  task automatic pulse_go(input bit dut_b);
    @(posedge clk); #1;
    if (dut_b) go_b = 1'b1; else go_a = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    go_a = 1'b0;
    go_b = 1'b0;
  endtask

  task automatic fill_vram(input bit pattern);
    for (int i = 0; i < 4096; i++) vram[i] = pattern ? (8'(i) ^ 8'h5A) : 8'($urandom);
  endtask

  task automatic test_reset;
    repeat (3) begin @(posedge clk); #1; end
    n_checks += 9;
    if (busrq_n_a !== 1'b1) begin n_fail++; $display("FAIL rst_busrq_n: got %b want 1", busrq_n_a); end
    if (dma_cs_a !== 1'b0) begin n_fail++; $display("FAIL rst_dma_cs: got %b want 0", dma_cs_a); end
    if (dma_addr_a !== OFS_A) begin n_fail++; $display("FAIL rst_dma_addr_a: got %h want %h", dma_addr_a, OFS_A); end
    if (dma_addr_b !== OFS_B) begin n_fail++; $display("FAIL rst_dma_addr_b: got %h want %h", dma_addr_b, OFS_B); end
    if (obj_addr_a !== 9'd0) begin n_fail++; $display("FAIL rst_obj_addr: got %h want 0", obj_addr_a); end
    if (obj_din_a !== 8'd0) begin n_fail++; $display("FAIL rst_obj_din: got %h want 0", obj_din_a); end
    if (obj_we_a !== 1'b0) begin n_fail++; $display("FAIL rst_obj_we: got %b want 0", obj_we_a); end
    if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy_a); end
    if (busrq_n_b !== 1'b1) begin n_fail++; $display("FAIL rst_busrq_n_b: got %b want 1", busrq_n_b); end
    rst = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
  endtask

  task automatic test_single;
    bit ok;
    int bad;
    fill_vram(1'b1);
    grant_dly = 3;
    log_a.delete();
    pulse_go(1'b0);
    wait_writes(1'b0, LEN_A, 8000, ok);
    n_checks += 2;
    if (!ok) begin n_fail++; $display("FAIL single_timeout: got %0d writes want %0d", log_a.size(), LEN_A); end
    if (busrq_n_a !== 1'b1) begin n_fail++; $display("FAIL single_release: busrq_n got %b want 1", busrq_n_a); end
    wait_idle(1'b0, 64, ok);
    bad = first_bad(1'b0, 0, LEN_A, OFS_A);
    n_checks += 3;
    if (!ok || busy_a !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b want 0", busy_a); end
    if (log_a.size() != LEN_A) begin n_fail++; $display("FAIL single_count: got %0d want %0d", log_a.size(), LEN_A); end
    if (bad != -1) begin n_fail++; $display("FAIL single_data: first bad byte %0d want none", bad); end
    $display("xfer single: %0d writes", log_a.size());
  endtask

  task automatic test_coalesce;
    bit ok;
    int bad0, bad1, n_extra;
    fill_vram(1'b0);
    grant_dly = int'($urandom_range(1, 5));
    log_a.delete();
    pulse_go(1'b0);
    wait_writes(1'b0, 60, 2000, ok);
    n_extra = 3;
    for (int p = 0; p < n_extra; p++) begin
      pulse_go(1'b0);
      repeat (int'($urandom_range(2, 10))) begin @(posedge clk); #1; end
    end
    wait_writes(1'b0, LEN_A * 2, 16000, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL coalesce_timeout: got %0d writes want %0d", log_a.size(), LEN_A * 2); end
    wait_idle(1'b0, 64, ok);
    repeat (200) begin @(posedge clk); #1; end
    bad0 = first_bad(1'b0, 0, LEN_A, OFS_A);
    bad1 = first_bad(1'b0, LEN_A, LEN_A, OFS_A);
    n_checks += 4;
    if (log_a.size() != LEN_A * (1 + (n_extra > 0 ? 1 : 0))) begin
      n_fail++; $display("FAIL coalesce_count: got %0d want %0d", log_a.size(), LEN_A * 2);
    end
    if (busy_a !== 1'b0) begin n_fail++; $display("FAIL coalesce_busy: got %b want 0", busy_a); end
    if (bad0 != -1) begin n_fail++; $display("FAIL coalesce_data1: first bad byte %0d want none", bad0); end
    if (bad1 != -1) begin n_fail++; $display("FAIL coalesce_data2: first bad byte %0d want none", bad1); end
    $display("xfer coalesce: %0d writes, grant delay %0d", log_a.size(), grant_dly);
  endtask

  task automatic test_bus_loss;
    bit ok;
    int bad;
    fill_vram(1'b0);
    grant_dly = int'($urandom_range(1, 4));
    log_a.delete();
    lost_writes = 0;
    pulse_go(1'b0);
    wait_writes(1'b0, 100, 2000, ok);
    lost_a = 10;
    repeat (9) begin @(posedge clk); #1; end
    n_checks += 2;
    if (dma_cs_a !== 1'b0) begin n_fail++; $display("FAIL loss_cs: got %b want 0", dma_cs_a); end
    if (busrq_n_a !== 1'b0) begin n_fail++; $display("FAIL loss_busrq: got %b want 0", busrq_n_a); end
    wait_writes(1'b0, LEN_A, 8000, ok);
    wait_idle(1'b0, 64, ok);
    bad = first_bad(1'b0, 0, LEN_A, OFS_A);
    n_checks += 3;
    if (lost_writes != 0) begin n_fail++; $display("FAIL loss_we: got %0d writes without bus want 0", lost_writes); end
    if (log_a.size() != LEN_A) begin n_fail++; $display("FAIL loss_count: got %0d want %0d", log_a.size(), LEN_A); end
    if (bad != -1) begin n_fail++; $display("FAIL loss_data: first bad byte %0d want none", bad); end
    $display("xfer bus_loss: %0d writes", log_a.size());
  endtask

  task automatic test_wrap;
    bit ok;
    int bad;
    fill_vram(1'b0);
    grant_dly = int'($urandom_range(1, 4));
    log_b.delete();
    pulse_go(1'b1);
    wait_writes(1'b1, LEN_B, 6000, ok);
    wait_idle(1'b1, 64, ok);
    bad = first_bad(1'b1, 0, LEN_B, OFS_B);
    n_checks += 4;
    if (log_b.size() != LEN_B) begin n_fail++; $display("FAIL wrap_count: got %0d want %0d", log_b.size(), LEN_B); end
    if (bad != -1) begin n_fail++; $display("FAIL wrap_data: first bad byte %0d want none", bad); end
    if (log_b.size() > 128 && log_b[128].data != int'(vram[0])) begin
      n_fail++; $display("FAIL wrap_byte128: got %h want %h", log_b[128].data, vram[0]);
    end
    if (busy_b !== 1'b0) begin n_fail++; $display("FAIL wrap_busy: got %b want 0", busy_b); end
    $display("xfer wrap: %0d writes", log_b.size());
  endtask

  task automatic test_reset_mid;
    bit ok;
    int bad;
    fill_vram(1'b0);
    log_a.delete();
    pulse_go(1'b0);
    wait_writes(1'b0, 40, 2000, ok);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks += 3;
    if (busrq_n_a !== 1'b1) begin n_fail++; $display("FAIL rstmid_busrq: got %b want 1", busrq_n_a); end
    if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy_a); end
    if (dma_cs_a !== 1'b0) begin n_fail++; $display("FAIL rstmid_cs: got %b want 0", dma_cs_a); end
    repeat (24) begin @(posedge clk); #1; end
    log_a.delete();
    pulse_go(1'b0);
    wait_writes(1'b0, LEN_A, 8000, ok);
    wait_idle(1'b0, 64, ok);
    bad = first_bad(1'b0, 0, LEN_A, OFS_A);
    n_checks += 2;
    if (log_a.size() != LEN_A) begin n_fail++; $display("FAIL rstmid_count: got %0d want %0d", log_a.size(), LEN_A); end
    if (bad != -1) begin n_fail++; $display("FAIL rstmid_data: first bad byte %0d want none", bad); end
    $display("xfer reset_restart: %0d writes", log_a.size());
  endtask

  task automatic test_vblank;
    bit ok;
    bit flag;
    int bad;
    fill_vram(1'b0);
    log_a.delete();
    LVBL = 1'b1;
    pulse_go(1'b0);
`ifdef JTPANG_OBJDMA_VBLANK_EN
    flag = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (busrq_n_a !== 1'b1) flag = 1'b0;
    end
    n_checks += 2;
    if (flag !== 1'b1) begin n_fail++; $display("FAIL vbl_hold: busrq_n went low during active video, want held high"); end
    if (busy_a !== 1'b1) begin n_fail++; $display("FAIL vbl_busy: got %b want 1", busy_a); end
    LVBL = 1'b0;
    wait_writes(1'b0, 50, 2000, ok);
    LVBL = 1'b1;
`else
    flag = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (busrq_n_a === 1'b0) flag = 1'b1;
    end
    n_checks++;
    if (flag !== 1'b1) begin n_fail++; $display("FAIL vbl_ignored: busrq_n stayed high, want low"); end
`endif
    wait_writes(1'b0, LEN_A, 8000, ok);
    wait_idle(1'b0, 64, ok);
    bad = first_bad(1'b0, 0, LEN_A, OFS_A);
    n_checks++;
    if (log_a.size() != LEN_A || bad != -1) begin
      n_fail++; $display("FAIL vbl_data: got %0d writes first bad %0d want %0d writes none bad", log_a.size(), bad, LEN_A);
    end
    LVBL = 1'b0;
    $display("xfer vblank: %0d writes", log_a.size());
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) vram[i] = 8'd0;
    test_reset;
    test_single;
    test_coalesce;
    test_bus_loss;
    test_wrap;
    test_reset_mid;
    test_vblank;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
